dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 2048, number of 32-bit words in the shared data memory.
REQ-002 The block SHALL have parameter ERR_CHECK, default 1, 1 = reject misaligned accesses.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 rqN_req  input  1  request from requester N (N=0 pipeline MEM stage, N=1 loader/debug port).
REQ-006 rqN_we  input  1  1 = store, 0 = load.
REQ-007 rqN_addr  input  32  byte address.
REQ-008 rqN_size  input  2  00 word, 01 byte, 10 half, 11 reserved (save_option encoding).
REQ-009 rqN_wdata  input  32  store data, right-aligned.
REQ-010 rqN_gnt  output  1  request accepted this cycle.
REQ-011 rqN_rvalid  output  1  response valid (one cycle pulse).
REQ-012 rqN_rdata  output  32  load data, full word as read from memory.
REQ-013 rqN_err  output  1  qualifies rvalid; access rejected.
REQ-014 mem_addr  output  32  address to memory.
REQ-015 mem_be  output  4  byte enables to memory.
REQ-016 mem_din  output  32  write data to memory.
REQ-017 mem_write  output  1  memory write strobe.
REQ-018 mem_dout  input  32  combinational read data from memory.

Function
REQ-019 At most one rqN_gnt SHALL be high per cycle; a grant is given in the same cycle as a sampled req, with no idle cycle between back-to-back grants.
REQ-020 Arbitration SHALL be round-robin: with both requesting, the requester not granted most recently wins; the last-grant pointer resets to 1, so requester 0 wins the first conflict.
REQ-021 A requester SHALL hold req, we, addr, size and wdata stable until gnt; dropping req before gnt is legal and cancels the request.
REQ-022 In a grant cycle mem_addr, mem_be, mem_din and mem_write SHALL be driven from the winner's signals combinationally; with no grant mem_write=0 and mem_be=0000.
REQ-023 mem_be SHALL be 1111 for word, 0011 for half, 0001 for byte, identical to the memory's BE convention; byte-lane placement is done by the memory from addr[1:0].
REQ-024 mem_write SHALL equal granted we AND NOT misaligned.
REQ-025 Misaligned is defined as word with addr[1:0]!=00, half with addr[0]=1, or size=11; when ERR_CHECK=1 such an access SHALL be granted, SHALL NOT write, and SHALL respond with err=1 and rdata=0.
REQ-026 When ERR_CHECK=0 only size=11 SHALL be treated as misaligned.
REQ-027 An address with byte index >= 4*MEM_WORDS SHALL respond err=1 and SHALL NOT write.
REQ-028 rqN_rvalid SHALL pulse exactly one cycle after rqN_gnt, for loads and stores alike.
REQ-029 rqN_rdata SHALL be mem_dout registered in the grant cycle, i.e. pre-write contents, and SHALL hold until the next rvalid to that requester.
REQ-030 The block SHALL keep a 2-state FSM per requester port, IDLE and RESP: IDLE->RESP on gnt, RESP->RESP on gnt, RESP->IDLE otherwise.
REQ-031 The block SHALL keep a 16-bit saturating stall counter per requester, counting cycles with req=1 and gnt=0; it clears on gnt and has no output.
REQ-032 If the stall counter reaches 15, that requester SHALL win the next conflict regardless of the round-robin pointer.

Reset
REQ-033 While reset=1 the block SHALL drive gnt=0, rvalid=0, err=0, rdata=0, mem_write=0, mem_be=0000; FSMs SHALL go to IDLE, the pointer to 1, and stall counters to 0.
REQ-034 Reset asserted in a grant cycle SHALL suppress that write, and no rvalid SHALL follow.
REQ-035 The first grant after reset SHALL be possible in the cycle after reset deasserts.

Structure
REQ-036 Size encodings (SZ_WORD, SZ_BYTE, SZ_HALF), BE constants and the FSM state typedef SHALL live in shared package dm_pkg.
REQ-037 Size-to-BE decode plus alignment check SHALL be one sub-module, dm_be_gen (inputs size and addr[1:0]; outputs be and misaligned), reused by the pipeline.

Verification
REQ-038 Reset, then rq0 word store 0x12345678 to addr 0x10 -> gnt0 in the same cycle, mem_be=1111, mem_write=1, rvalid0 next cycle with err=0.
REQ-039 rq0 and rq1 both load every cycle for 4 cycles -> grants alternate 0,1,0,1, and each rvalid follows its grant by one cycle.
REQ-040 rq1 half store to addr 0x13 -> gnt1, mem_write=0, rvalid1 with err1=1, and memory unchanged.
REQ-041 rq0 byte store 0xAB to 0x21, then word load 0x20 -> second response rdata[15:8]=0xAB.
REQ-042 rq0 held at req=1 while rq1 wins repeatedly (forced by a test hook) -> rq0 granted no later than its 16th stalled cycle.
REQ-043 reset asserted in a grant cycle -> no write and no rvalid the next cycle.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: access sizes, byte-enable
// patterns and the per-requester response FSM state.
package dm_pkg;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int STALL_W = 16;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_NONE = 4'b0000;

  localparam logic [STALL_W-1:0] STALL_LIMIT = 16'd15;

  typedef logic [0:0] dm_state_t;
  localparam dm_state_t ST_IDLE = 1'b0;
  localparam dm_state_t ST_RESP = 1'b1;
endpackage

// File: rtl/dm_arbiter_if.sv
// Requester-side and memory-side bundles of the data-memory arbiter.
interface dm_rq_if;
  import dm_pkg::*;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, size, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, size, wdata, output gnt, rvalid, rdata, err);
endinterface

interface dm_mem_if;
  import dm_pkg::*;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [DATA_W-1:0] din;
  logic              write;
  logic [DATA_W-1:0] dout;

  modport master (output addr, be, din, write, input dout);
  modport slave  (input addr, be, din, write, output dout);
endinterface

// File: rtl/dm_be_gen.sv
// Size-to-byte-enable decode with alignment check; lane placement is left to
// the memory, so enables are always right-aligned.
module dm_be_gen import dm_pkg::*; #(
  parameter bit ERR_CHECK = 1'b1
) (
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       misaligned
);
  always_comb begin
    be         = BE_NONE;
    misaligned = 1'b0;
    case (size)
      SZ_WORD: begin
        be         = BE_WORD;
        misaligned = ERR_CHECK && (addr_lo != 2'b00);
      end
      SZ_HALF: begin
        be         = BE_HALF;
        misaligned = ERR_CHECK && addr_lo[0];
      end
      SZ_BYTE: be = BE_BYTE;
      default: misaligned = 1'b1;
    endcase
  end
endmodule

// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory with
// a one-cycle registered response per requester.
module dm_arbiter import dm_pkg::*; #(
  parameter int MEM_WORDS = 2048,
  parameter bit ERR_CHECK = 1'b1
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     test_prio1,
  dm_rq_if.slave   rq0,
  dm_rq_if.slave   rq1,
  dm_mem_if.master mem
);
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(4 * MEM_WORDS);

  logic [1:0]        req, gnt, hungry, rvalid, err;
  logic [DATA_W-1:0] rdata [2];
  logic              last_gnt;
  logic              pick1, any_gnt;
  logic              w_we, w_mis, w_oor, w_bad;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_size;
  logic [DATA_W-1:0] w_wdata;
  logic [3:0]        w_be;

  assign req = reset ? 2'b00 : {rq1.req, rq0.req};

  // A starving requester overrides both the pointer and the test hook.
  always_comb begin
    pick1 = 1'b0;
    if (req == 2'b10) begin
      pick1 = 1'b1;
    end else if (req == 2'b11) begin
      if (hungry[0] && !hungry[1])      pick1 = 1'b0;
      else if (hungry[1] && !hungry[0]) pick1 = 1'b1;
      else if (test_prio1)              pick1 = 1'b1;
      else                              pick1 = ~last_gnt;
    end
  end

  assign gnt     = {req[1] & pick1, req[0] & ~pick1};
  assign any_gnt = |gnt;

  assign w_we    = pick1 ? rq1.we    : rq0.we;
  assign w_addr  = pick1 ? rq1.addr  : rq0.addr;
  assign w_size  = pick1 ? rq1.size  : rq0.size;
  assign w_wdata = pick1 ? rq1.wdata : rq0.wdata;

  dm_be_gen #(.ERR_CHECK(ERR_CHECK)) u_be_gen (
    .size       (w_size),
    .addr_lo    (w_addr[1:0]),
    .be         (w_be),
    .misaligned (w_mis)
  );

  assign w_oor = w_addr >= MEM_BYTES;
  assign w_bad = w_mis | w_oor;

  assign mem.addr  = any_gnt ? w_addr  : '0;
  assign mem.be    = any_gnt ? w_be    : BE_NONE;
  assign mem.din   = any_gnt ? w_wdata : '0;
  assign mem.write = any_gnt & w_we & ~w_bad;

  always_ff @(posedge clock) begin
    if (reset)        last_gnt <= 1'b1;
    else if (any_gnt) last_gnt <= gnt[1];
  end

  // Stage p1: response captured from the grant cycle, pre-write read data.
  for (genvar i = 0; i < 2; i++) begin : g_rsp
    dm_state_t          state_p1;
    logic               err_p1;
    logic [DATA_W-1:0]  rdata_p1;
    logic [STALL_W-1:0] stall;

    always_ff @(posedge clock) begin
      if (reset) begin
        state_p1 <= ST_IDLE;
        err_p1   <= 1'b0;
        rdata_p1 <= '0;
        stall    <= '0;
      end else begin
        state_p1 <= gnt[i] ? ST_RESP : ST_IDLE;
        err_p1   <= gnt[i] & w_bad;
        if (gnt[i]) rdata_p1 <= w_bad ? '0 : mem.dout;
        if (gnt[i])                      stall <= '0;
        else if (req[i] && stall != '1) stall <= stall + 1'b1;
      end
    end

    assign hungry[i] = stall >= STALL_LIMIT;
    assign rvalid[i] = ~reset & (state_p1 == ST_RESP);
    assign err[i]    = rvalid[i] & err_p1;
    assign rdata[i]  = reset ? '0 : rdata_p1;
  end

  assign rq0.gnt    = gnt[0];
  assign rq1.gnt    = gnt[1];
  assign rq0.rvalid = rvalid[0];
  assign rq1.rvalid = rvalid[1];
  assign rq0.err    = err[0];
  assign rq1.err    = err[1];
  assign rq0.rdata  = rdata[0];
  assign rq1.rdata  = rdata[1];
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, multi-cycle corner sequences and
// random traffic checked against a rule-level reference model.
`timescale 1ns/1ps
module tb_dm_arbiter;
  import dm_pkg::*;

  localparam int MEMW = 64;

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } rq_t;

  typedef struct {
    bit          who;
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          wr;
    bit          err;
    logic [31:0] mask;
    logic [31:0] rexp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic test_prio1 = 1'b0;
  always #5 clk = ~clk;

  dm_rq_if  rq0 ();
  dm_rq_if  rq1 ();
  dm_mem_if mbus ();

  dm_arbiter #(.MEM_WORDS(MEMW), .ERR_CHECK(1'b1)) dut (
    .clock      (clk),
    .reset      (reset),
    .test_prio1 (test_prio1),
    .rq0        (rq0),
    .rq1        (rq1),
    .mem        (mbus)
  );

  // Memory: combinational read, byte lanes placed from addr[1:0].
  logic [31:0] hmem [MEMW] = '{default: 32'h0};
  assign mbus.dout = (mbus.addr < 32'(4*MEMW)) ? hmem[mbus.addr[7:2]] : 32'h0;
  always @(posedge clk) begin
    if (mbus.write && mbus.addr < 32'(4*MEMW)) begin
      case (mbus.be)
        4'b1111: hmem[mbus.addr[7:2]] <= mbus.din;
        4'b0011: hmem[mbus.addr[7:2]][{mbus.addr[1], 4'b0000} +: 16] <= mbus.din[15:0];
        4'b0001: hmem[mbus.addr[7:2]][{mbus.addr[1:0], 3'b000} +: 8] <= mbus.din[7:0];
        default: ;
      endcase
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          ts [2];
  int          stall_m [2];
  logic [31:0] shadow [MEMW];
  bit          exp_rv [2];
  bit          exp_err [2];
  logic [31:0] exp_rd [2];
  int          cyc = 0;
  int          last_w = -1;

  task automatic model_cycle();
    bit r [2];
    bit we, mis, oor, bad, wr;
    logic [31:0] a, wd;
    logic [1:0] sz;
    logic [3:0] be_e;
    int w;
    r[0] = !reset && rq0.req;
    r[1] = !reset && rq1.req;
    w = -1;
    if (r[0] && r[1]) begin
      if (stall_m[0] >= 15 && stall_m[1] < 15)      w = 0;
      else if (stall_m[1] >= 15 && stall_m[0] < 15) w = 1;
      else if (test_prio1)                          w = 1;
      else                                          w = (ts[0] < ts[1]) ? 0 : 1;
    end else if (r[0]) w = 0;
    else if (r[1])     w = 1;

    we = 1'b0; a = 32'h0; sz = 2'b00; wd = 32'h0;
    if (w == 0) begin we = rq0.we; a = rq0.addr; sz = rq0.size; wd = rq0.wdata; end
    if (w == 1) begin we = rq1.we; a = rq1.addr; sz = rq1.size; wd = rq1.wdata; end
    mis  = (sz == SZ_RSVD) || (sz == SZ_WORD && a[1:0] != 2'b00) || (sz == SZ_HALF && a[0]);
    oor  = a >= 32'(4*MEMW);
    bad  = mis || oor;
    wr   = (w >= 0) && we && !bad;
    be_e = (sz == SZ_WORD) ? 4'b1111 : (sz == SZ_BYTE) ? 4'b0001 : 4'b0011;

    check("m_gnt0", 32'(rq0.gnt), 32'(w == 0));
    check("m_gnt1", 32'(rq1.gnt), 32'(w == 1));
    check("m_write", 32'(mbus.write), 32'(wr));
    if (w < 0) begin
      check("m_be_idle", 32'(mbus.be), 32'h0);
    end else begin
      check("m_addr", mbus.addr, a);
      if (sz != SZ_RSVD) check("m_be", 32'(mbus.be), 32'(be_e));
      if (we) check("m_din", mbus.din, wd);
    end

    check("m_rvalid0", 32'(rq0.rvalid), 32'(!reset && exp_rv[0]));
    check("m_rvalid1", 32'(rq1.rvalid), 32'(!reset && exp_rv[1]));
    check("m_rdata0", rq0.rdata, reset ? 32'h0 : exp_rd[0]);
    check("m_rdata1", rq1.rdata, reset ? 32'h0 : exp_rd[1]);
    if (!reset && exp_rv[0]) check("m_err0", 32'(rq0.err), 32'(exp_err[0]));
    if (!reset && exp_rv[1]) check("m_err1", 32'(rq1.err), 32'(exp_err[1]));

    if (reset) begin
      ts[0] = -2; ts[1] = -1;
      for (int i = 0; i < 2; i++) begin
        stall_m[i] = 0; exp_rv[i] = 1'b0; exp_err[i] = 1'b0; exp_rd[i] = 32'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_rv[i] = (w == i);
        if (w == i)    stall_m[i] = 0;
        else if (r[i]) stall_m[i]++;
      end
      if (w >= 0) begin
        exp_err[w] = bad;
        exp_rd[w]  = bad ? 32'h0 : shadow[a[7:2]];
        ts[w]      = cyc;
        if (wr) begin
          case (sz)
            SZ_BYTE: shadow[a[7:2]][8*a[1:0] +: 8] = wd[7:0];
            SZ_HALF: shadow[a[7:2]][16*a[1] +: 16] = wd[15:0];
            default: shadow[a[7:2]] = wd;
          endcase
        end
      end
    end
    last_w = w;
    cyc++;
  endtask

  logic n_reset = 1'b1;
  bit   n_prio = 1'b0;
  rq_t  nq [2];

  task automatic step();
    @(posedge clk);
    #1;
    reset      = n_reset;
    test_prio1 = n_prio;
    rq0.req = nq[0].req; rq0.we = nq[0].we; rq0.addr = nq[0].addr;
    rq0.size = nq[0].size; rq0.wdata = nq[0].wdata;
    rq1.req = nq[1].req; rq1.we = nq[1].we; rq1.addr = nq[1].addr;
    rq1.size = nq[1].size; rq1.wdata = nq[1].wdata;
    #4;
    model_cycle();
  endtask

  task automatic set_rq(input int i, input bit req, input bit we, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata);
    nq[i] = '{req, we, addr, size, wdata};
  endtask

  task automatic idle();
    set_rq(0, 1'b0, 1'b0, 32'h0, SZ_WORD, 32'h0);
    set_rq(1, 1'b0, 1'b0, 32'h0, SZ_WORD, 32'h0);
  endtask

  vec_t vt [12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bit got;
    logic [1:0] exp_g, prev_g;

    for (int i = 0; i < MEMW; i++) shadow[i] = 32'h0;
    ts[0] = -2; ts[1] = -1;
    for (int i = 0; i < 2; i++) begin exp_rd[i] = 32'h0; stall_m[i] = 0; end
    rq0.req = 0; rq0.we = 0; rq0.addr = 0; rq0.size = 0; rq0.wdata = 0;
    rq1.req = 0; rq1.we = 0; rq1.addr = 0; rq1.size = 0; rq1.wdata = 0;

    vt[0]  = '{1'b0, 1'b1, 32'h010, SZ_WORD, 32'h12345678, 4'b1111, 1'b1, 1'b0, 32'h0,        32'h0};
    vt[1]  = '{1'b1, 1'b1, 32'h013, SZ_HALF, 32'h0000FFFF, 4'b0011, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 32'h021, SZ_BYTE, 32'h000000AB, 4'b0001, 1'b1, 1'b0, 32'h0,        32'h0};
    vt[3]  = '{1'b0, 1'b0, 32'h020, SZ_WORD, 32'h0,        4'b1111, 1'b0, 1'b0, 32'h0000FF00, 32'h0000AB00};
    vt[4]  = '{1'b1, 1'b1, 32'h104, SZ_WORD, 32'hCAFEF00D, 4'b1111, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0};
    vt[5]  = '{1'b0, 1'b0, 32'h030, SZ_RSVD, 32'h0,        4'b0000, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0};
    vt[6]  = '{1'b1, 1'b1, 32'h032, SZ_HALF, 32'h0000BEEF, 4'b0011, 1'b1, 1'b0, 32'h0,        32'h0};
    vt[7]  = '{1'b0, 1'b0, 32'h030, SZ_WORD, 32'h0,        4'b1111, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hBEEF0000};
    vt[8]  = '{1'b1, 1'b1, 32'h0FF, SZ_BYTE, 32'h0000005A, 4'b0001, 1'b1, 1'b0, 32'h0,        32'h0};
    vt[9]  = '{1'b0, 1'b0, 32'h0FC, SZ_WORD, 32'h0,        4'b1111, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h5A000000};
    vt[10] = '{1'b0, 1'b1, 32'h100, SZ_BYTE, 32'h00000011, 4'b0001, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0};
    vt[11] = '{1'b1, 1'b0, 32'h031, SZ_WORD, 32'h0,        4'b1111, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0};

    // Reset held with a pending store: nothing may be granted or written.
    idle();
    n_reset = 1'b1;
    set_rq(0, 1'b1, 1'b1, 32'h040, SZ_WORD, 32'hDEAD0001);
    repeat (3) step();
    check("rst_gnt0", 32'(rq0.gnt), 32'h0);
    check("rst_write", 32'(mbus.write), 32'h0);
    check("rst_be", 32'(mbus.be), 32'h0);
    check("rst_rvalid0", 32'(rq0.rvalid), 32'h0);
    check("rst_rdata0", rq0.rdata, 32'h0);

    n_reset = 1'b0;
    step();
    check("first_gnt_after_rst", 32'(rq0.gnt), 32'h1);
    check("first_write_after_rst", 32'(mbus.write), 32'h1);
    idle();
    step();
    check("first_rvalid0", 32'(rq0.rvalid), 32'h1);

    for (int i = 0; i < 12; i++) begin
      idle();
      set_rq(int'(vt[i].who), 1'b1, vt[i].we, vt[i].addr, vt[i].size, vt[i].wdata);
      step();
      check($sformatf("vec%0d_gnt", i), 32'(vt[i].who ? rq1.gnt : rq0.gnt), 32'h1);
      check($sformatf("vec%0d_write", i), 32'(mbus.write), 32'(vt[i].wr));
      if (vt[i].size != SZ_RSVD) check($sformatf("vec%0d_be", i), 32'(mbus.be), 32'(vt[i].be));
      idle();
      step();
      check($sformatf("vec%0d_rvalid", i), 32'(vt[i].who ? rq1.rvalid : rq0.rvalid), 32'h1);
      check($sformatf("vec%0d_err", i), 32'(vt[i].who ? rq1.err : rq0.err), 32'(vt[i].err));
      if (vt[i].mask != 32'h0)
        check($sformatf("vec%0d_rdata", i), (vt[i].who ? rq1.rdata : rq0.rdata) & vt[i].mask, vt[i].rexp);
    end
    check("mem_unchanged_0x10", hmem[4], 32'h12345678);

    // Back-to-back conflicts right after reset: 0 wins first, then alternate.
    idle();
    n_reset = 1'b1;
    step();
    n_reset = 1'b0;
    set_rq(0, 1'b1, 1'b0, 32'h010, SZ_WORD, 32'h0);
    set_rq(1, 1'b1, 1'b0, 32'h020, SZ_WORD, 32'h0);
    prev_g = 2'b00;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("rr_gnt_%0d", k), 32'({rq1.gnt, rq0.gnt}), 32'(exp_g));
      check($sformatf("rr_rvalid_%0d", k), 32'({rq1.rvalid, rq0.rvalid}), 32'(prev_g));
      prev_g = exp_g;
    end
    idle();
    step();
    check("rr_rvalid_last", 32'({rq1.rvalid, rq0.rvalid}), 32'(prev_g));

    // Reset landing on a would-be grant cycle.
    step();
    n_reset = 1'b1;
    set_rq(0, 1'b1, 1'b1, 32'h044, SZ_WORD, 32'h77777777);
    step();
    check("rstgnt_gnt0", 32'(rq0.gnt), 32'h0);
    check("rstgnt_write", 32'(mbus.write), 32'h0);
    n_reset = 1'b0;
    idle();
    step();
    check("rstgnt_no_rvalid", 32'(rq0.rvalid), 32'h0);
    check("rstgnt_mem", hmem[17], 32'h0);

    // Hook favours rq1; starvation override must let rq0 through.
    n_prio = 1'b1;
    set_rq(0, 1'b1, 1'b0, 32'h000, SZ_WORD, 32'h0);
    set_rq(1, 1'b1, 1'b0, 32'h004, SZ_WORD, 32'h0);
    got = 1'b0;
    waited = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      step();
      if (rq0.gnt) begin got = 1'b1; waited = k; end
    end
    check("stall_override_cycle", 32'(waited), 32'd16);
    n_prio = 1'b0;
    idle();
    step();

    // Random traffic, honouring hold-until-grant with occasional cancels.
    for (int c = 0; c < 500; c++) begin
      n_reset = ($urandom_range(0, 99) == 0);
      n_prio  = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < 2; i++) begin
        if (nq[i].req && last_w != i && $urandom_range(0, 9) != 0) begin
          // keep the pending request unchanged
        end else begin
          set_rq(i, ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 32'h13F)), 2'($urandom_range(0, 3)), $urandom);
        end
      end
      step();
    end
    n_reset = 1'b0;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
